digitmem_reader: RTL and testbench
==================================

# digitmem_reader

Sequential read-out engine for the 8×8-bit switch-programmed digit memory. It walks the memory's synchronous read port address by address and latches each byte into the two-digit seven-segment display. Each address is held for a programmable dwell time, with a one-hot LED marking the shown address. It sits on the read side of the memory, opposite the switch-driven write path, and supports free-running scan, one-pass scan and manual single-step.

## Interface
Parameters:
- DWELL, 50_000_000: number of clock cycles each address is displayed in run mode; must be ≥ 1.
- LOOP, 1: 1 = wrap 7→0 and scan forever; 0 = stop after address 7.

Ports:
- clk  input  1  the single clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: begin a scan at address 0.
- stop  input  1  single-cycle pulse: abort to idle; the display keeps its last value.
- step  input  1  single-cycle pulse, honoured in idle only: read and show the cursor address once.
- rd_en  output  1  read strobe to the memory.
- rd_addr  output  3  read address.
- rd_data  input  8  memory data, valid the cycle after rd_en.
- shown_addr  output  3  address of the byte currently displayed.
- shown_value  output  8  byte currently displayed.
- indicate_led  output  8  one-hot of shown_addr (1 << shown_addr).
- digit_number1  output  7  seven-segment code of shown_value[3:0], via the existing hex2seven_seg.
- digit_number2  output  7  seven-segment code of shown_value[7:4], via hex2seven_seg.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a LOOP=0 pass completes.

## Operation
- State machine has 4 states: IDLE, REQ, WAIT, SHOW. Internal registers: a 3-bit cursor, a run flag and a dwell counter of width $clog2(DWELL+1).
- IDLE:
  - start → cursor=0, run=1, go to REQ.
  - step → run=0, go to REQ using the current cursor.
  - Otherwise stay in IDLE.
- REQ: drive rd_en=1 and rd_addr=cursor for exactly one cycle, then go to WAIT.
- WAIT: rd_data is valid this cycle. Latch shown_value←rd_data and shown_addr←cursor at the end of the cycle, and advance cursor←cursor+1 (mod 8).
  - If run=1: load dwell counter with DWELL−1, go to SHOW.
  - If run=0 (step): go to IDLE.
- SHOW: decrement the counter each cycle. When it reads 0, leave:
  - LOOP=1: go to REQ.
  - LOOP=0 and the shown address was 7: pulse done, set run=0, go to IDLE. Cursor has already wrapped to 0.
  - LOOP=0 otherwise: go to REQ.
- rd_en is 0 in every state except REQ. rd_addr always equals cursor.
- Input priority: stop > start > step.
  - stop is honoured in any state; the next state is IDLE and run=0.
  - If stop arrives in WAIT, the capture is abandoned: shown_value, shown_addr and cursor are all unchanged.
  - start and step are ignored while busy.
- Display outputs are driven combinationally from the shown_* registers.

## Timing
- Reset values: state IDLE; cursor 0; run 0; rd_en 0; rd_addr 0; shown_addr 0; shown_value 8'h00; indicate_led 8'h01; digits show "00"; busy 0; done 0.
- start sampled high at the edge ending cycle N:
  - cycle N+1: REQ, rd_en=1, rd_addr=0.
  - cycle N+2: WAIT.
  - cycle N+3: shown_value = mem[0].
- In run mode each address is displayed for DWELL+2 cycles: 1 REQ + 1 WAIT + DWELL SHOW. With LOOP=1 this gives a full 8-address period of 8·(DWELL+2) cycles.
- step from IDLE: the new value is visible 3 cycles after the pulse, and busy is high for exactly 2 cycles.
- done pulses high during the single cycle after the last SHOW cycle of address 7, i.e. the first cycle back in IDLE.
- reset asserted in any state returns every output to its reset value at the next edge; reset overrides all inputs.

## Test plan
- DWELL=4, LOOP=1, memory holds mem[i]=8'h11·i. Pulse start → rd_addr sequence 0,1,…,7,0 with rd_en pulses 6 cycles apart. shown_value tracks 00,11,…,77,00 and indicate_led tracks 01,02,…,80,01.
- DWELL=4, LOOP=0, same memory. Pulse start → after address 7 is shown for 4 cycles, done is high for 1 cycle, busy=0, and shown_value stays 8'h77. A following step shows mem[0]=00.
- IDLE after reset, pulse step three times, ≥4 cycles apart → shown_addr 0,1,2 and shown_value 00,11,22, each 3 cycles after its pulse; busy never exceeds 2 cycles.
- Running scan, pulse stop on a WAIT cycle while reading address 3 → next cycle IDLE, shown_value stays 8'h22, cursor stays 3. A later step shows 8'h33.
- start and stop asserted together in IDLE → stays IDLE, rd_en stays 0. start during SHOW → ignored, and the scan cadence is unchanged.
- reset asserted mid-SHOW at address 5 → next cycle: shown_value 00, indicate_led 01, busy 0, rd_en 0, digits "00".

Source files
------------

// File: rtl/digitmem_reader.sv
`default_nettype none
// ============================================================================
// Module   : digitmem_reader (+ hex2seven_seg)
// Brief    : Sequential read-out of an 8x8-bit digit memory onto two 7-seg digits
// Revision : 1.0 - initial release
// ============================================================================

// Hex to seven-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
module hex2seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
endmodule

module digitmem_reader #(
  parameter int DWELL = 50_000_000,
  parameter int LOOP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  output logic       rd_en,
  output logic [2:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [2:0] shown_addr,
  output logic [7:0] shown_value,
  output logic [7:0] indicate_led,
  output logic [6:0] digit_number1,
  output logic [6:0] digit_number2,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] C_DWELL_LOAD = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cursor_q, cursor_d;
  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    shown_addr_q, shown_addr_d;
  logic [7:0]    shown_value_q, shown_value_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cursor_q      <= 3'd0;
      run_q         <= 1'b0;
      cnt_q         <= '0;
      shown_addr_q  <= 3'd0;
      shown_value_q <= 8'h00;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      run_q         <= run_d;
      cnt_q         <= cnt_d;
      shown_addr_q  <= shown_addr_d;
      shown_value_q <= shown_value_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    run_d         = run_q;
    cnt_d         = cnt_q;
    shown_addr_d  = shown_addr_q;
    shown_value_d = shown_value_q;
    done_d        = 1'b0;
    // stop wins everywhere; in WAIT this also drops the pending capture
    if (stop) begin
      state_d = IDLE;
      run_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cursor_d = 3'd0;
            run_d    = 1'b1;
            state_d  = REQ;
          end else if (step) begin
            run_d   = 1'b0;
            state_d = REQ;
          end
        end
        REQ: state_d = WAIT;
        WAIT: begin
          shown_value_d = rd_data;
          shown_addr_d  = cursor_q;
          cursor_d      = cursor_q + 3'd1;
          if (run_q) begin
            cnt_d   = C_DWELL_LOAD;
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            if (LOOP == 0 && shown_addr_q == 3'd7) begin
              done_d  = 1'b1;
              run_d   = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = REQ;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rd_en        = (state_q == REQ);
  assign rd_addr      = cursor_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign shown_addr   = shown_addr_q;
  assign shown_value  = shown_value_q;
  assign indicate_led = 8'b0000_0001 << shown_addr_q;

  hex2seven_seg u_seg_lo (.hex(shown_value_q[3:0]), .seg(digit_number1));
  hex2seven_seg u_seg_hi (.hex(shown_value_q[7:4]), .seg(digit_number2));

endmodule
`default_nettype wire

// File: tb/tb_digitmem_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_digitmem_reader
// Brief    : Directed self-checking bench; instance a runs LOOP=1, b runs LOOP=0
// Revision : 1.0 - initial release
// ============================================================================
module tb_digitmem_reader;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0;
  int   pass_cnt = 0, total_cnt = 0;

  logic       a_rd_en, a_busy, a_done, b_rd_en, b_busy, b_done;
  logic [2:0] a_rd_addr, a_shown_addr, b_rd_addr, b_shown_addr;
  logic [7:0] a_rd_data = 8'h00, b_rd_data = 8'h00;
  logic [7:0] a_shown_value, a_led, b_shown_value, b_led;
  logic [6:0] a_d1, a_d2, b_d1, b_d2;

  always #5 clk = ~clk;

  // memory content is mem[i] = 8'h11 * i, read synchronously
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= 8'h11 * {5'd0, a_rd_addr};
    if (b_rd_en) b_rd_data <= 8'h11 * {5'd0, b_rd_addr};
  end

  digitmem_reader #(.DWELL(4), .LOOP(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .shown_addr(a_shown_addr), .shown_value(a_shown_value), .indicate_led(a_led),
    .digit_number1(a_d1), .digit_number2(a_d2), .busy(a_busy), .done(a_done)
  );

  digitmem_reader #(.DWELL(4), .LOOP(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .shown_addr(b_shown_addr), .shown_value(b_shown_value), .indicate_led(b_led),
    .digit_number1(b_d1), .digit_number2(b_d2), .busy(b_busy), .done(b_done)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if ({a_rd_en, a_busy, a_done} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {a_rd_en, a_busy, a_done}); else pass_cnt++;
    total_cnt++; if ({a_rd_addr, a_shown_addr} !== 6'd0) $display("FAIL reset_addr: got %h want 00", {a_rd_addr, a_shown_addr}); else pass_cnt++;
    total_cnt++; if (a_shown_value !== 8'h00) $display("FAIL reset_value: got %h want 00", a_shown_value); else pass_cnt++;
    total_cnt++; if (a_led !== 8'h01) $display("FAIL reset_led: got %h want 01", a_led); else pass_cnt++;
    total_cnt++; if ({a_d2, a_d1} !== {7'h3F, 7'h3F}) $display("FAIL reset_digits: got %h/%h want 3f/3f", a_d2, a_d1); else pass_cnt++;
  endtask

  task automatic test_loop_scan();
    logic [2:0] ad;
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      ad = 3'(k);
      total_cnt++; if (a_rd_en !== 1'b1 || a_rd_addr !== ad) $display("FAIL loop_req%0d: got en=%b addr=%0d want en=1 addr=%0d", k, a_rd_en, a_rd_addr, ad); else pass_cnt++;
      tick(1);
      total_cnt++; if (a_rd_en !== 1'b0) $display("FAIL loop_wait_en%0d: got %b want 0", k, a_rd_en); else pass_cnt++;
      tick(1);
      total_cnt++; if (a_shown_value !== 8'h11 * {5'd0, ad} || a_led !== (8'h01 << ad)) $display("FAIL loop_show%0d: got val=%h led=%h want val=%h led=%h", k, a_shown_value, a_led, 8'h11 * {5'd0, ad}, 8'h01 << ad); else pass_cnt++;
      tick(4);
    end
    stop = 1'b1; tick(1); stop = 1'b0;
    total_cnt++; if (a_busy !== 1'b0) $display("FAIL loop_stop_busy: got %b want 0", a_busy); else pass_cnt++;
  endtask

  task automatic test_one_pass();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    tick(42);
    total_cnt++; if (b_rd_en !== 1'b1 || b_rd_addr !== 3'd7) $display("FAIL pass_req7: got en=%b addr=%0d want en=1 addr=7", b_rd_en, b_rd_addr); else pass_cnt++;
    tick(5);
    total_cnt++; if (b_done !== 1'b0 || b_busy !== 1'b1 || b_shown_value !== 8'h77) $display("FAIL pass_last_show: got done=%b busy=%b val=%h want 0 1 77", b_done, b_busy, b_shown_value); else pass_cnt++;
    tick(1);
    total_cnt++; if (b_done !== 1'b1 || b_busy !== 1'b0 || b_shown_value !== 8'h77) $display("FAIL pass_done: got done=%b busy=%b val=%h want 1 0 77", b_done, b_busy, b_shown_value); else pass_cnt++;
    tick(1);
    total_cnt++; if (b_done !== 1'b0 || b_busy !== 1'b0 || b_rd_en !== 1'b0) $display("FAIL pass_after: got done=%b busy=%b en=%b want 0 0 0", b_done, b_busy, b_rd_en); else pass_cnt++;
    step = 1'b1; tick(1); step = 1'b0;
    total_cnt++; if (b_rd_en !== 1'b1 || b_rd_addr !== 3'd0) $display("FAIL pass_step_req: got en=%b addr=%0d want en=1 addr=0", b_rd_en, b_rd_addr); else pass_cnt++;
    tick(2);
    total_cnt++; if (b_shown_value !== 8'h00 || b_led !== 8'h01 || b_busy !== 1'b0) $display("FAIL pass_step_show: got val=%h led=%h busy=%b want 00 01 0", b_shown_value, b_led, b_busy); else pass_cnt++;
  endtask

  task automatic test_step();
    logic [2:0] ad;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ad = 3'(i);
      step = 1'b1; tick(1); step = 1'b0;
      total_cnt++; if (a_busy !== 1'b1) $display("FAIL step%0d_busy1: got %b want 1", i, a_busy); else pass_cnt++;
      tick(1);
      total_cnt++; if (a_busy !== 1'b1) $display("FAIL step%0d_busy2: got %b want 1", i, a_busy); else pass_cnt++;
      tick(1);
      total_cnt++; if (a_busy !== 1'b0 || a_shown_addr !== ad || a_shown_value !== 8'h11 * {5'd0, ad}) $display("FAIL step%0d_show: got busy=%b addr=%0d val=%h want 0 %0d %h", i, a_busy, a_shown_addr, a_shown_value, ad, 8'h11 * {5'd0, ad}); else pass_cnt++;
      tick(1);
    end
  endtask

  task automatic test_stop_in_wait();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    tick(18);
    total_cnt++; if (a_rd_en !== 1'b1 || a_rd_addr !== 3'd3) $display("FAIL stop_req3: got en=%b addr=%0d want en=1 addr=3", a_rd_en, a_rd_addr); else pass_cnt++;
    tick(1);
    stop = 1'b1; tick(1); stop = 1'b0;
    total_cnt++; if (a_busy !== 1'b0 || a_shown_value !== 8'h22 || a_shown_addr !== 3'd2 || a_rd_addr !== 3'd3) $display("FAIL stop_wait: got busy=%b val=%h saddr=%0d cur=%0d want 0 22 2 3", a_busy, a_shown_value, a_shown_addr, a_rd_addr); else pass_cnt++;
    tick(3);
    total_cnt++; if (a_busy !== 1'b0 || a_rd_en !== 1'b0) $display("FAIL stop_idle: got busy=%b en=%b want 0 0", a_busy, a_rd_en); else pass_cnt++;
    step = 1'b1; tick(1); step = 1'b0;
    tick(2);
    total_cnt++; if (a_shown_value !== 8'h33 || a_d1 !== 7'h4F || a_d2 !== 7'h4F) $display("FAIL stop_step: got val=%h d=%h/%h want 33 4f/4f", a_shown_value, a_d2, a_d1); else pass_cnt++;
  endtask

  task automatic test_start_stop();
    do_reset();
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    total_cnt++; if (a_busy !== 1'b0 || a_rd_en !== 1'b0) $display("FAIL startstop: got busy=%b en=%b want 0 0", a_busy, a_rd_en); else pass_cnt++;
    tick(1);
    total_cnt++; if (a_busy !== 1'b0 || a_rd_en !== 1'b0) $display("FAIL startstop_hold: got busy=%b en=%b want 0 0", a_busy, a_rd_en); else pass_cnt++;
  endtask

  task automatic test_start_in_show();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    total_cnt++; if (a_rd_en !== 1'b0 || a_shown_value !== 8'h00) $display("FAIL show_start_hold: got en=%b val=%h want 0 00", a_rd_en, a_shown_value); else pass_cnt++;
    tick(1);
    total_cnt++; if (a_rd_en !== 1'b1 || a_rd_addr !== 3'd1) $display("FAIL show_start_cadence: got en=%b addr=%0d want en=1 addr=1", a_rd_en, a_rd_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    tick(33);
    total_cnt++; if (a_shown_value !== 8'h55 || a_led !== 8'h20 || a_d1 !== 7'h6D || a_d2 !== 7'h6D) $display("FAIL mid_show5: got val=%h led=%h d=%h/%h want 55 20 6d/6d", a_shown_value, a_led, a_d2, a_d1); else pass_cnt++;
    reset = 1'b1; tick(1); reset = 1'b0;
    total_cnt++; if (a_shown_value !== 8'h00 || a_led !== 8'h01 || a_busy !== 1'b0 || a_rd_en !== 1'b0) $display("FAIL mid_reset: got val=%h led=%h busy=%b en=%b want 00 01 0 0", a_shown_value, a_led, a_busy, a_rd_en); else pass_cnt++;
    total_cnt++; if (a_d1 !== 7'h3F || a_d2 !== 7'h3F) $display("FAIL mid_reset_digits: got %h/%h want 3f/3f", a_d2, a_d1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loop_scan();
    test_one_pass();
    test_step();
    test_stop_in_wait();
    test_start_stop();
    test_start_in_show();
    test_reset_mid_show();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
